alu_pipe: RTL and testbench

- Registered, handshaked ALU for the processor datapath. Parametrised successor of the combinational core ALU.
- Adds the following over that ALU:
  - a valid/ready interface on both sides
  - an iterative multi-cycle multiplier
  - signed compare and arithmetic shift
  - status flags
  - an illegal-opcode indication
  - a tag that passes through with each operation
- Sits between the operand-fetch/decode stage and writeback in each core. A tag identifies the destination register or thread.

---
 rtl/alu_pipe.sv | 172 +++++++++++++++++
 tb/tb_alu_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered valid/ready ALU with an iterative radix-2 multiplier, status flags and a pass-through tag.
// Latency: 1 cycle for single-cycle ops; MUL presents its result DATAPATH_WIDTH+1 cycles after accept.
// Backpressure: in_ready drops while a result is held untaken or a MUL is iterating; held outputs stay stable.
module alu_pipe #(
    parameter int DATAPATH_WIDTH = 64,
    parameter int SHAMT_WIDTH    = 6,
    parameter int TAG_WIDTH      = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATAPATH_WIDTH-1:0] a_in,
    input  logic [DATAPATH_WIDTH-1:0] b_in,
    input  logic [3:0]                alu_ctrl_in,
    input  logic [TAG_WIDTH-1:0]      tag_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATAPATH_WIDTH-1:0] accum_out,
    output logic [TAG_WIDTH-1:0]      tag_out,
    output logic                      zero_out,
    output logic                      carry_out,
    output logic                      ovf_out,
    output logic                      illegal_out
);

    localparam int W = DATAPATH_WIDTH;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    localparam logic [SHAMT_WIDTH:0] MUL_LAST = (SHAMT_WIDTH+1)'(W);
    localparam logic [SHAMT_WIDTH:0] CNT_ONE  = (SHAMT_WIDTH+1)'(1);

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t state, state_nxt;

    logic                   accept;
    logic                   mul_done;
    logic [W-1:0]           mul_a;
    logic [W-1:0]           mul_b;
    logic [W-1:0]           mul_acc;
    logic [SHAMT_WIDTH:0]   mul_cnt;
    logic [TAG_WIDTH-1:0]   mul_tag;

    logic [SHAMT_WIDTH-1:0] shamt;
    logic [W:0]             sum;
    logic [W:0]             diff;
    logic [W-1:0]           res;
    logic                   res_carry;
    logic                   res_ovf;
    logic                   res_illegal;

    assign shamt    = b_in[SHAMT_WIDTH-1:0];
    assign sum      = {1'b0, a_in} + {1'b0, b_in};
    // Top bit of the widened difference is the unsigned borrow.
    assign diff     = {1'b0, a_in} - {1'b0, b_in};
    assign accept   = in_valid && in_ready;
    assign mul_done = (state == MUL_BUSY) && (mul_cnt == MUL_LAST);

    always_comb begin
        res         = '0;
        res_carry   = 1'b0;
        res_ovf     = 1'b0;
        res_illegal = 1'b0;
        case (alu_ctrl_in)
            OP_ADD: begin
                res       = sum[W-1:0];
                res_carry = sum[W];
                res_ovf   = (a_in[W-1] == b_in[W-1]) && (sum[W-1] != a_in[W-1]);
            end
            OP_SUB: begin
                res       = diff[W-1:0];
                res_carry = diff[W];
                res_ovf   = (a_in[W-1] != b_in[W-1]) && (diff[W-1] != a_in[W-1]);
            end
            OP_AND:  res = a_in & b_in;
            OP_OR:   res = a_in | b_in;
            OP_NOT:  res = ~a_in;
            OP_XOR:  res = a_in ^ b_in;
            OP_SLL:  res = a_in << shamt;
            OP_SRL:  res = a_in >> shamt;
            OP_SRA:  res = W'($signed(a_in) >>> shamt);
            OP_SLT:  res = {{(W-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
            OP_SLTU: res = {{(W-1){1'b0}}, (a_in < b_in)};
            OP_MUL:  res = '0;
            default: res_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept && alu_ctrl_in == OP_MUL) state_nxt = MUL_BUSY;
            MUL_BUSY: if (mul_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) && (!out_valid || out_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            accum_out   <= '0;
            tag_out     <= '0;
            zero_out    <= 1'b0;
            carry_out   <= 1'b0;
            ovf_out     <= 1'b0;
            illegal_out <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_acc     <= '0;
            mul_cnt     <= '0;
            mul_tag     <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                if (alu_ctrl_in == OP_MUL) begin
                    mul_a   <= a_in;
                    mul_b   <= b_in;
                    mul_tag <= tag_in;
                    mul_acc <= '0;
                    mul_cnt <= '0;
                end else begin
                    accum_out   <= res;
                    tag_out     <= tag_in;
                    zero_out    <= (res == '0);
                    carry_out   <= res_carry;
                    ovf_out     <= res_ovf;
                    illegal_out <= res_illegal;
                    out_valid   <= 1'b1;
                end
            end else if (state == MUL_BUSY) begin
                // W shift-add iterations, then one extra cycle to publish the product.
                if (mul_done) begin
                    accum_out   <= mul_acc;
                    tag_out     <= mul_tag;
                    zero_out    <= (mul_acc == '0);
                    carry_out   <= 1'b0;
                    ovf_out     <= 1'b0;
                    illegal_out <= 1'b0;
                    out_valid   <= 1'b1;
                end else begin
                    if (mul_b[0]) mul_acc <= mul_acc + mul_a;
                    mul_a   <= mul_a << 1;
                    mul_b   <= mul_b >> 1;
                    mul_cnt <= mul_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors push expected results; a negedge monitor pops and compares.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic [3:0]  alu_ctrl_in;
    logic [4:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] accum_out;
    logic [4:0]  tag_out;
    logic        zero_out;
    logic        carry_out;
    logic        ovf_out;
    logic        illegal_out;

    typedef struct packed {
        logic [4:0]  tag;
        logic [63:0] res;
        logic        z;
        logic        c;
        logic        o;
        logic        il;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_pop_cyc = -10;
    int   run = 0;

    alu_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .alu_ctrl_in(alu_ctrl_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .accum_out(accum_out), .tag_out(tag_out),
        .zero_out(zero_out), .carry_out(carry_out), .ovf_out(ovf_out), .illegal_out(illegal_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got res=%h tag=%0d, required no output", accum_out, tag_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (accum_out !== e.res || tag_out !== e.tag || zero_out !== e.z ||
                    carry_out !== e.c || ovf_out !== e.o || illegal_out !== e.il) begin
                    fails++;
                    $display("FAIL result_tag%0d: got res=%h tag=%0d z%b c%b o%b il%b, required res=%h tag=%0d z%b c%b o%b il%b",
                             e.tag, accum_out, tag_out, zero_out, carry_out, ovf_out, illegal_out,
                             e.res, e.tag, e.z, e.c, e.o, e.il);
                end
            end
            run = (cyc == last_pop_cyc + 1) ? run + 1 : 1;
            last_pop_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic expect_res(input logic [4:0] tag, input logic [63:0] res,
                              input logic z, input logic c, input logic o, input logic il);
        exp_t e;
        e.tag = tag; e.res = res; e.z = z; e.c = c; e.o = o; e.il = il;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag, output int waited);
        in_valid = 1'b1; alu_ctrl_in = op; a_in = a; b_in = b; tag_in = tag;
        waited = 0;
        #1;
        while (!in_ready && waited < 500) begin
            @(posedge clk); #2;
            waited++;
        end
        if (waited >= 500) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int w;
        int lat;
        logic bad;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_in = '0; b_in = '0; alu_ctrl_in = '0; tag_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_accum", accum_out, 64'd0);
        check("reset_tag_flags", {54'd0, tag_out, zero_out, carry_out, ovf_out, illegal_out}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        // ADD wraps to zero with carry, result one cycle after accept.
        expect_res(5'd3, 64'd0, 1, 1, 0, 0);
        send(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, w);
        check("add_latency_valid", {63'd0, out_valid}, 64'd1);

        expect_res(5'd4, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 0);
        send(4'd1, 64'h8000_0000_0000_0000, 64'd1, 5'd4, w);
        expect_res(5'd5, 64'd1, 0, 0, 0, 0);
        send(4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd5, w);
        expect_res(5'd6, 64'd0, 1, 0, 0, 0);
        send(4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd6, w);
        expect_res(5'd7, 64'hF800_0000_0000_000F, 0, 0, 0, 0);
        send(4'd8, 64'h8000_0000_0000_00F0, 64'h44, 5'd7, w);
        expect_res(5'd8, 64'h0800_0000_0000_000F, 0, 0, 0, 0);
        send(4'd7, 64'h8000_0000_0000_00F0, 64'h44, 5'd8, w);
        expect_res(5'd9, 64'h0000_0000_0000_0F00, 0, 0, 0, 0);
        send(4'd6, 64'h8000_0000_0000_00F0, 64'h44, 5'd9, w);
        @(posedge clk); #1;

        // MUL: busy for the iterations, result at accept+65.
        expect_res(5'd10, 64'd83810205, 0, 0, 0, 0);
        send(4'd11, 64'd12345, 64'd6789, 5'd10, w);
        bad = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (in_ready || out_valid) bad = 1'b1;
            @(posedge clk); #1;
        end
        check("mul_busy_in_ready_low", {63'd0, bad}, 64'd0);
        lat = 64;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        check("mul_latency", 64'(lat), 64'd65);
        @(posedge clk); #1;
        expect_res(5'd11, 64'd0, 1, 0, 0, 0);
        send(4'd11, 64'h8000_0000_0000_0000, 64'd2, 5'd11, w);
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;

        // Backpressure: held result stays stable, illegal op waits.
        out_ready = 1'b0;
        expect_res(5'd12, 64'd2, 0, 0, 0, 0);
        send(4'd0, 64'd1, 64'd1, 5'd12, w);
        expect_res(5'd13, 64'd0, 1, 0, 0, 1);
        in_valid = 1'b1; alu_ctrl_in = 4'd13; a_in = 64'd77; b_in = 64'd5; tag_in = 5'd13;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (in_ready || !out_valid || accum_out !== 64'd2 || tag_out !== 5'd12) bad = 1'b1;
            @(posedge clk); #1;
        end
        check("hold_stable", {63'd0, bad}, 64'd0);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("illegal_presented", {63'd0, out_valid}, 64'd1);

        // Stream of 8 single-cycle ops, one per cycle.
        expect_res(5'd20, 64'hF000, 0, 0, 0, 0);
        send(4'd2, 64'hF0F0, 64'hFF00, 5'd20, w);
        check("stream_no_stall_0", 64'(w), 64'd0);
        expect_res(5'd21, 64'hFFFF, 0, 0, 0, 0);
        send(4'd3, 64'hF0F0, 64'h0F0F, 5'd21, w);
        expect_res(5'd22, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
        send(4'd4, 64'd0, 64'd0, 5'd22, w);
        expect_res(5'd23, 64'd0, 1, 0, 0, 0);
        send(4'd5, 64'hAAAA, 64'hAAAA, 5'd23, w);
        expect_res(5'd24, 64'h8000_0000_0000_0000, 0, 0, 1, 0);
        send(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd24, w);
        expect_res(5'd25, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 0);
        send(4'd1, 64'd3, 64'd5, 5'd25, w);
        expect_res(5'd26, 64'd1, 0, 0, 0, 0);
        send(4'd6, 64'd1, 64'h40, 5'd26, w);
        expect_res(5'd27, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
        send(4'd8, 64'h8000_0000_0000_0000, 64'd63, 5'd27, w);
        check("stream_no_stall_7", 64'(w), 64'd0);
        @(posedge clk); #1;
        check("stream_consecutive", 64'(run >= 8), 64'd1);

        // Reset during MUL_BUSY discards the product.
        send(4'd11, 64'd7, 64'd9, 5'd30, w);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        reset = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        check("abort_no_stale", {63'd0, out_valid}, 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
